ram_window_reader: RTL and testbench

- Consumer side of the step-to-address-window decoder. Takes a half-open RAM window [first_addr, last_addr) plus a read strobe, and sequences single-word reads from the shared picture/weight RAM.
- Streams the returned words, each tagged with its offset in the window, to the convolution/dense datapath over a valid/ready handshake.
- Sits between the step decoder and the compute stages. Replaces ad-hoc address counters in each stage.

---
 rtl/nn_mem_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/ram_window_reader.sv | 161 ++++++++++++++++
 tb/tb_ram_window_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// Shared constants and types for the NN memory subsystem: word/address widths,
// the picture/weight RAM memory map and the window-reader state encoding.
package nn_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 15;
  localparam int unsigned MEM_DATA_W = 19;

  // Exclusive end address of each region in the shared picture/weight RAM
  localparam int unsigned PICTURE_LIMIT = 784;
  localparam int unsigned CONV1         = 820;
  localparam int unsigned CONV2         = 1108;
  localparam int unsigned CONV3         = 1396;
  localparam int unsigned CONV4         = 1684;
  localparam int unsigned CONV5         = 1972;
  localparam int unsigned CONV6         = 2260;
  localparam int unsigned DENSE         = 3000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and same-cycle push/pop; a push into a
// full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 34,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ram_window_reader.sv
// Sequences single-word reads over a half-open RAM window and streams the words,
// tagged with their window offset, through a credit-protected skid FIFO.
module ram_window_reader
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_RAM,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
  localparam int unsigned USE_W = CNT_W + 1;
  localparam int unsigned FW    = ADDR_W + DATA_W;

  reader_state_e     state_q;
  logic              re_prev_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] push_idx_q;
  logic              ram_re_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [RD_LAT-1:0] vld_sr_q;
  logic [CNT_W-1:0]  inflight_q;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] issue_addr;
  logic [USE_W-1:0]  used;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rdata;

  // Space already spoken for: queued words plus reads still in the RAM pipe,
  // less the word leaving this cycle.
  always_comb begin
    push       = vld_sr_q[RD_LAT-1];
    pop        = ~fifo_empty & out_ready;
    accept     = (state_q == IDLE) & re_RAM & ~re_prev_q;
    used       = USE_W'(fifo_count) + USE_W'(inflight_q) - USE_W'(pop);
    issue_addr = (state_q == IDLE) ? first_addr : cur_q;
    issue      = 1'b0;
    case (state_q)
      IDLE:    issue = accept & (last_addr > first_addr);
      READ:    issue = (used < USE_W'(FIFO_D));
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      re_prev_q  <= 1'b0;
      cur_q      <= '0;
      last_q     <= '0;
      ram_addr_q <= '0;
      push_idx_q <= '0;
      ram_re_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_sr_q   <= '0;
      inflight_q <= '0;
    end else begin
      re_prev_q   <= re_RAM;
      done_q      <= 1'b0;
      ram_re_q    <= issue;
      vld_sr_q[0] <= ram_re_q;
      for (int unsigned i = 1; i < RD_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
      inflight_q  <= inflight_q + CNT_W'(issue) - CNT_W'(push);
      if (issue) begin
        ram_addr_q <= issue_addr;
        cur_q      <= issue_addr + ADDR_W'(1);
      end
      if (push) push_idx_q <= push_idx_q + ADDR_W'(1);

      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            push_idx_q <= '0;
            last_q     <= last_addr;
            if (last_addr == first_addr) begin
              state_q <= DONE;
            end else if (last_addr < first_addr) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (first_addr + ADDR_W'(1) == last_addr) begin
              state_q <= DRAIN;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue && (cur_q + ADDR_W'(1) == last_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (used == '0) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({push_idx_q, ram_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Credit accounting must make a push into a full FIFO impossible.
  no_overflow_a: assert property (@(posedge clk) disable iff (rst) push |-> (!fifo_full || pop));

  assign ram_addr  = ram_addr_q;
  assign ram_re    = ram_re_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign out_idx   = fifo_rdata[FW-1:DATA_W];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ram_window_reader.sv
// Directed bench for ram_window_reader: one instance at RD_LAT=1 for the window
// scenarios and reset abort, one at RD_LAT=2 for the backpressure stall.
module tb_ram_window_reader;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] a_first, a_last, a_ram_addr, a_out_idx;
  logic [DW-1:0] a_ram_rdata, a_out_data;
  logic          a_re, a_ram_re, a_out_valid, a_out_ready, a_busy, a_done, a_err;

  logic [AW-1:0] b_first, b_last, b_ram_addr, b_out_idx;
  logic [DW-1:0] b_ram_rdata, b_out_data;
  logic          b_re, b_ram_re, b_out_valid, b_out_ready, b_busy, b_done, b_err;

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = DW'(a);
    return (t * 19'd37) ^ 19'h25A5A;
  endfunction

  ram_window_reader #(.RD_LAT(1), .FIFO_D(4)) u_dut_a (
    .clk(clk), .rst(rst), .re_RAM(a_re), .first_addr(a_first), .last_addr(a_last),
    .ram_addr(a_ram_addr), .ram_re(a_ram_re), .ram_rdata(a_ram_rdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .busy(a_busy), .done(a_done), .err(a_err)
  );

  ram_window_reader #(.RD_LAT(2), .FIFO_D(4)) u_dut_b (
    .clk(clk), .rst(rst), .re_RAM(b_re), .first_addr(b_first), .last_addr(b_last),
    .ram_addr(b_ram_addr), .ram_re(b_ram_re), .ram_rdata(b_ram_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .busy(b_busy), .done(b_done), .err(b_err)
  );

  // RAM models: registered read, data RD_LAT cycles after the address
  logic [DW-1:0] a_pipe;
  logic [DW-1:0] b_pipe0, b_pipe1;
  always @(posedge clk) begin
    a_pipe  <= data_of(a_ram_addr);
    b_pipe0 <= data_of(b_ram_addr);
    b_pipe1 <= b_pipe0;
  end
  assign a_ram_rdata = a_pipe;
  assign b_ram_rdata = b_pipe1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int r_issued, r_got, r_first_valid, r_done_cycle, r_last_hs, r_done_cnt, r_bad, r_max_out;
  logic r_err_c0, r_err_at_done, r_busy_at_done, r_aborted;

  // Drive one request on instance A and record what comes back, cycle by cycle.
  task automatic run_window(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input bit toggle, input int abort_at);
    int c;
    int budget;
    r_issued = 0; r_got = 0; r_first_valid = -1; r_done_cycle = -1; r_last_hs = -1;
    r_done_cnt = 0; r_bad = 0; r_max_out = 0;
    r_err_c0 = 1'bx; r_err_at_done = 1'bx; r_busy_at_done = 1'bx; r_aborted = 1'b0;
    budget = ((l > f) ? int'(l - f) : 0) * 4 + 40;
    @(negedge clk);
    a_first = f; a_last = l; a_re = 1'b1;
    @(negedge clk);
    a_re = 1'b0;
    c = 0;
    while (c < budget) begin
      if (a_ram_re) begin
        if (a_ram_addr !== f + AW'(r_issued)) r_bad++;
        r_issued++;
      end
      if (a_done) begin
        r_done_cnt++;
        if (r_done_cycle < 0) begin
          r_done_cycle   = c;
          r_busy_at_done = a_busy;
          r_err_at_done  = a_err;
        end
      end
      if (c == 0) r_err_c0 = a_err;
      if (a_out_valid && r_first_valid < 0) r_first_valid = c;
      if (r_issued - r_got > r_max_out) r_max_out = r_issued - r_got;
      a_out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (a_out_valid && a_out_ready) begin
        if (a_out_idx !== AW'(r_got) || a_out_data !== data_of(f + AW'(r_got))) r_bad++;
        r_got++;
        r_last_hs = c;
      end
      if (abort_at >= 0 && r_got == abort_at) begin
        r_aborted = 1'b1;
        break;
      end
      if (r_done_cycle >= 0 && c >= r_done_cycle + 2) break;
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int dn;
    rst = 1'b1;
    a_re = 1'b0; a_first = '0; a_last = '0; a_out_ready = 1'b0;
    b_re = 1'b0; b_first = '0; b_last = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.ram_re", a_ram_re, 0);
    check("reset.ram_addr", a_ram_addr, 0);
    check("reset.out_valid", a_out_valid, 0);
    check("reset.busy_done_err", {a_busy, a_done, a_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // conv1 weights, consumer always ready
    run_window(15'd784, 15'd820, 1'b0, -1);
    check("t1.words", r_got, 36);
    check("t1.reads", r_issued, 36);
    check("t1.order", r_bad, 0);
    check("t1.first_valid_cycle", r_first_valid, 2);
    check("t1.one_per_cycle", r_last_hs - r_first_valid, 35);
    check("t1.done_after_last", r_done_cycle, r_last_hs + 2);
    check("t1.done_pulses", r_done_cnt, 1);
    check("t1.busy_at_done", r_busy_at_done, 0);
    check("t1.err_at_done", r_err_at_done, 0);

    // same window under 1,0,0,1 backpressure
    run_window(15'd784, 15'd820, 1'b1, -1);
    check("t2.words", r_got, 36);
    check("t2.reads", r_issued, 36);
    check("t2.order", r_bad, 0);
    check("t2.outstanding_le_depth", r_max_out <= 4, 1);
    check("t2.done_pulses", r_done_cnt, 1);

    // empty window
    run_window(15'd820, 15'd820, 1'b0, -1);
    check("t3.reads", r_issued, 0);
    check("t3.no_valid", r_first_valid, -1);
    check("t3.done_cycle", r_done_cycle, 1);
    check("t3.err", r_err_at_done, 0);

    // inverted window, then a valid request clears err
    run_window(15'd900, 15'd800, 1'b0, -1);
    check("t4.reads", r_issued, 0);
    check("t4.err", r_err_at_done, 1);
    check("t4.done_pulses", r_done_cnt, 1);
    check("t4.err_sticky", a_err, 1);
    run_window(15'd0, 15'd784, 1'b0, -1);
    check("t4b.err_cleared", r_err_c0, 0);
    check("t4b.words", r_got, 784);
    check("t4b.order", r_bad, 0);
    check("t4b.done_pulses", r_done_cnt, 1);

    // reset in the middle of a long window
    run_window(15'd0, 15'd784, 1'b0, 10);
    check("t5.reached_abort", r_aborted, 1);
    rst = 1'b1;
    #1;
    check("t5.ram_re", a_ram_re, 0);
    check("t5.ram_addr", a_ram_addr, 0);
    check("t5.out_valid", a_out_valid, 0);
    check("t5.out_data", a_out_data, 0);
    check("t5.out_idx", a_out_idx, 0);
    check("t5.busy_done_err", {a_busy, a_done, a_err}, 0);
    dn = 0;
    repeat (2) begin @(negedge clk); if (a_done) dn++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (a_done) dn++; end
    check("t5.no_done", dn, 0);
    run_window(15'd784, 15'd820, 1'b0, -1);
    check("t5b.words", r_got, 36);
    check("t5b.order", r_bad, 0);
    check("t5b.first_valid_cycle", r_first_valid, 2);

    // RD_LAT=2 instance: stall with consumer not ready, then drain
    begin
      int iss, got, bad, dcnt;
      iss = 0; got = 0; bad = 0; dcnt = 0;
      @(negedge clk);
      b_first = 15'd3000; b_last = 15'd3008; b_re = 1'b1; b_out_ready = 1'b0;
      @(negedge clk);
      b_re = 1'b0;
      for (c = 0; c < 10; c++) begin
        if (b_ram_re) iss++;
        @(negedge clk);
      end
      check("t6.reads_while_stalled", iss, 4);
      check("t6.valid_while_stalled", b_out_valid, 1);
      check("t6.idx_held", b_out_idx, 0);
      for (c = 0; c < 60 && dcnt == 0; c++) begin
        if (b_ram_re) begin
          if (b_ram_addr !== 15'd3000 + AW'(iss)) bad++;
          iss++;
        end
        if (b_done) dcnt++;
        b_out_ready = 1'b1;
        if (b_out_valid) begin
          if (b_out_idx !== AW'(got) || b_out_data !== data_of(15'd3000 + AW'(got))) bad++;
          got++;
        end
        @(negedge clk);
      end
      check("t6.reads", iss, 8);
      check("t6.words", got, 8);
      check("t6.order", bad, 0);
      check("t6.done", dcnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
